// File: rtl/compressed_frame_parser_pkg.sv
// Shared types and helpers for the compressed frame parser.
// page_size_t  : size field carried in headers and metadata
// frame_hdr_t  : 32-bit page header {uncompressed size, compressed size}
// frame_meta_t : per-page metadata record handed to writeback
// keep_popcount: number of valid bytes in a beat, pre-widened for size sums
package compressed_frame_parser_pkg;

    localparam int unsigned PAGE_SIZE_BITS = 16;
    localparam int unsigned KEEP_BITS      = 64;

    typedef logic [PAGE_SIZE_BITS-1:0] page_size_t;

    typedef struct packed {
        page_size_t uncom;
        page_size_t com;
    } frame_hdr_t;

    typedef struct packed {
        page_size_t uncom;
        page_size_t com;
        page_size_t rcvd;
        logic       last;
        logic       err;
    } frame_meta_t;

    function automatic logic [PAGE_SIZE_BITS:0] keep_popcount(input logic [KEEP_BITS-1:0] keep);
        logic [PAGE_SIZE_BITS:0] n;
        n = '0;
        for (int unsigned i = 0; i < KEEP_BITS; i++) begin
            n = n + {{PAGE_SIZE_BITS{1'b0}}, keep[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/compressed_frame_parser_meta_slot.sv
// Single-entry metadata register slice.
// aclk, aresetn  : clock, synchronous active-low reset
// load_i         : write load_data_i into the slot (only when can_load_o)
// can_load_o     : slot is empty or is being drained this cycle
// meta_o         : held record, stable while valid and not accepted
// meta_valid_o   : record present
// meta_ready_i   : consumer accepts the record
module frame_meta_slot
    import compressed_frame_parser_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        load_i,
    input  frame_meta_t load_data_i,
    output logic        can_load_o,
    output frame_meta_t meta_o,
    output logic        meta_valid_o,
    input  logic        meta_ready_i
);

    frame_meta_t meta_q;
    logic        valid_q;

    assign can_load_o   = !valid_q || meta_ready_i;
    assign meta_o       = meta_q;
    assign meta_valid_o = valid_q;

    // A load wins over a drain, so load-and-drain in one cycle keeps valid set.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            meta_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            meta_q  <= load_data_i;
            valid_q <= 1'b1;
        end else if (valid_q && meta_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/compressed_frame_parser.sv
// Strips the 32-bit header of each page in the framed compressed stream,
// forwards the body with tlast per page and emits one metadata record per page.
// aclk, aresetn           : clock, synchronous active-low reset
// s_t*                    : framed input stream (header beat + body beats)
// m_t*                    : body payload, zero-latency passthrough in BODY
// meta_* / meta_valid/ready : per-page record {uncom, com, rcvd, last, err}
// page_count              : pages completed since reset (wraps)
// err_count               : pages flagged err since reset (saturates)
module compressed_frame_parser
    import compressed_frame_parser_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 512,
    parameter int unsigned SIZE_WIDTH  = 16,
    parameter int unsigned HEADER_SIZE = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [DATA_BITS-1:0]    s_tdata,
    input  logic [DATA_BITS/8-1:0]  s_tkeep,
    input  logic                    s_tlast,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic [DATA_BITS-1:0]    m_tdata,
    output logic [DATA_BITS/8-1:0]  m_tkeep,
    output logic                    m_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [SIZE_WIDTH-1:0]   meta_uncom,
    output logic [SIZE_WIDTH-1:0]   meta_com,
    output logic [SIZE_WIDTH-1:0]   meta_rcvd,
    output logic                    meta_last,
    output logic                    meta_err,
    output logic                    meta_valid,
    input  logic                    meta_ready,
    output logic [31:0]             page_count,
    output logic [15:0]             err_count
);

    typedef enum logic {S_HEADER, S_BODY} state_t;

    state_t                  state_q;
    frame_hdr_t              hdr_q;
    page_size_t              cnt_q;
    logic [31:0]             page_count_q;
    logic [15:0]             err_count_q;

    frame_hdr_t              hdr_in;
    logic [PAGE_SIZE_BITS:0] ones;
    logic [PAGE_SIZE_BITS:0] nxt;
    logic                    final_beat;
    logic                    hdr_bad;
    logic                    gate;
    logic                    hs;
    logic                    meta_load;
    frame_meta_t             meta_d;
    frame_meta_t             slot_meta;
    logic                    slot_can_load;

    frame_meta_slot u_meta_slot (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .load_i       (meta_load),
        .load_data_i  (meta_d),
        .can_load_o   (slot_can_load),
        .meta_o       (slot_meta),
        .meta_valid_o (meta_valid),
        .meta_ready_i (meta_ready)
    );

    assign m_tdata = s_tdata;
    assign m_tkeep = s_tkeep;

    always_comb begin
        hdr_in     = frame_hdr_t'(s_tdata[HEADER_SIZE-1:0]);
        ones       = keep_popcount(s_tkeep);
        nxt        = {1'b0, cnt_q} + ones;
        final_beat = (nxt >= {1'b0, hdr_q.com}) || s_tlast;
        hdr_bad    = (s_tkeep[HEADER_SIZE/8-1:0] != '1) || (hdr_in.com == '0) || s_tlast;
        gate       = 1'b0;
        s_tready   = 1'b0;
        m_tvalid   = 1'b0;
        m_tlast    = 1'b0;
        meta_load  = 1'b0;
        meta_d     = '0;
        if (aresetn) begin
            case (state_q)
                S_HEADER: begin
                    s_tready = slot_can_load;
                    if (s_tvalid && hdr_bad && slot_can_load) begin
                        meta_load = 1'b1;
                        meta_d    = '{uncom: hdr_in.uncom, com: hdr_in.com, rcvd: '0,
                                      last: s_tlast, err: 1'b1};
                    end
                end
                default: begin
                    gate     = !final_beat || slot_can_load;
                    s_tready = m_tready && gate;
                    // A final beat waiting on the meta slot is hidden downstream
                    // as well, so it can never be accepted twice.
                    m_tvalid = s_tvalid && gate;
                    m_tlast  = final_beat;
                    if (s_tvalid && s_tready && final_beat) begin
                        meta_load = 1'b1;
                        meta_d    = '{uncom: hdr_q.uncom, com: hdr_q.com,
                                      rcvd: nxt[PAGE_SIZE_BITS-1:0], last: s_tlast,
                                      err: (nxt != {1'b0, hdr_q.com})};
                    end
                end
            endcase
        end
        hs = s_tvalid && s_tready;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= S_HEADER;
            hdr_q        <= '0;
            cnt_q        <= '0;
            page_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            case (state_q)
                S_HEADER: begin
                    if (hs) begin
                        hdr_q <= hdr_in;
                        cnt_q <= '0;
                        if (!hdr_bad) state_q <= S_BODY;
                    end
                end
                default: begin
                    if (hs) begin
                        if (final_beat) state_q <= S_HEADER;
                        else            cnt_q   <= nxt[PAGE_SIZE_BITS-1:0];
                    end
                end
            endcase
            if (meta_load) begin
                page_count_q <= page_count_q + 32'd1;
                if (meta_d.err && (err_count_q != 16'hFFFF)) err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign meta_uncom = slot_meta.uncom;
    assign meta_com   = slot_meta.com;
    assign meta_rcvd  = slot_meta.rcvd;
    assign meta_last  = slot_meta.last;
    assign meta_err   = slot_meta.err;
    assign page_count = page_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_compressed_frame_parser.sv
module tb_compressed_frame_parser;

    localparam int DB = 512;
    localparam int KB = 64;

    typedef struct {
        logic [DB-1:0] data;
        logic [KB-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [15:0] uncom;
        logic [15:0] com;
        logic [15:0] rcvd;
        logic        last;
        logic        err;
    } meta_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DB-1:0] s_tdata = '0;
    logic [KB-1:0] s_tkeep = '0;
    logic          s_tlast = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DB-1:0] m_tdata;
    logic [KB-1:0] m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [15:0]   meta_uncom, meta_com, meta_rcvd;
    logic          meta_last, meta_err, meta_valid;
    logic          meta_ready = 1'b1;
    logic [31:0]   page_count;
    logic [15:0]   err_count;

    compressed_frame_parser #(.DATA_BITS(512), .SIZE_WIDTH(16), .HEADER_SIZE(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .meta_uncom(meta_uncom), .meta_com(meta_com), .meta_rcvd(meta_rcvd), .meta_last(meta_last),
        .meta_err(meta_err), .meta_valid(meta_valid), .meta_ready(meta_ready),
        .page_count(page_count), .err_count(err_count)
    );

    always #5 aclk = ~aclk;

    beat_t in_q[$];
    beat_t exp_out[$];
    beat_t obs_out[$];
    meta_t exp_meta[$];
    meta_t obs_meta[$];

    int checks = 0;
    int errors = 0;
    int stall_cycles = 0;
    int stab_viol = 0;
    int m_mode = 0;      // 0 always ready, 1 random, 2 held low
    int meta_mode = 0;
    bit gaps = 1'b0;

    // Ready generators, updated at the falling edge
    always @(negedge aclk) begin
        m_tready   = (m_mode == 0) ? 1'b1 : (m_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        meta_ready = (meta_mode == 0) ? 1'b1 : (meta_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Monitor: records handshakes that complete at the next rising edge
    bit    hold_prev = 1'b0;
    meta_t prev_meta;
    always begin
        @(negedge aclk);
        #2;
        if (aresetn) begin
            if (hold_prev && (!meta_valid || {meta_uncom, meta_com, meta_rcvd, meta_last, meta_err} !== prev_meta))
                stab_viol++;
            hold_prev = meta_valid && !meta_ready;
            prev_meta = {meta_uncom, meta_com, meta_rcvd, meta_last, meta_err};
            if (m_tvalid && m_tready) obs_out.push_back('{m_tdata, m_tkeep, m_tlast});
            if (meta_valid && meta_ready)
                obs_meta.push_back({meta_uncom, meta_com, meta_rcvd, meta_last, meta_err});
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

    function automatic logic [DB-1:0] rand_data();
        logic [DB-1:0] d;
        for (int w = 0; w < DB / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic beat_t mk_hdr(input logic [15:0] u, input logic [15:0] c, input logic [3:0] k, input logic l);
        beat_t b;
        b.data       = rand_data();
        b.data[31:0] = {u, c};
        b.keep       = {60'b0, k};
        b.last       = l;
        return b;
    endfunction

    function automatic beat_t mk_body(input int nb, input logic l);
        beat_t b;
        b.data = rand_data();
        b.keep = (nb >= 64) ? '1 : ((64'd1 << nb) - 64'd1);
        b.last = l;
        return b;
    endfunction

    // Reference: parse the raw beat list page by page using byte sums
    function automatic void run_model();
        int          i;
        int          bytes;
        int unsigned c;
        logic [15:0] u;
        beat_t       h;
        beat_t       b;
        bit          fin;
        exp_out.delete();
        exp_meta.delete();
        i = 0;
        while (i < in_q.size()) begin
            h = in_q[i];
            i++;
            u = h.data[31:16];
            c = int'(h.data[15:0]);
            if (h.keep[3:0] != 4'hF || c == 0 || h.last) begin
                exp_meta.push_back({u, 16'(c), 16'h0, h.last, 1'b1});
                continue;
            end
            bytes = 0;
            while (i < in_q.size()) begin
                b = in_q[i];
                i++;
                bytes += $countones(b.keep);
                fin = (bytes >= c) || b.last;
                exp_out.push_back('{b.data, b.keep, fin});
                if (fin) begin
                    exp_meta.push_back({u, 16'(c), 16'(bytes), b.last, 1'(bytes != c)});
                    break;
                end
            end
        end
    endfunction

    task automatic do_reset();
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        repeat (3) @(negedge aclk);
        obs_out.delete();
        obs_meta.delete();
        stall_cycles = 0;
        stab_viol    = 0;
        aresetn      = 1'b1;
    endtask

    task automatic send_all();
        int guard;
        @(negedge aclk);
        foreach (in_q[k]) begin
            if (gaps) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge aclk);
            end
            s_tdata  = in_q[k].data;
            s_tkeep  = in_q[k].keep;
            s_tlast  = in_q[k].last;
            s_tvalid = 1'b1;
            guard    = 0;
            forever begin
                #1;
                if (s_tready) begin
                    @(negedge aclk);
                    break;
                end
                stall_cycles++;
                guard++;
                if (guard > 3000) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout got s_tready=0 want 1 at beat %0d", k);
                    s_tvalid = 1'b0;
                    return;
                end
                @(negedge aclk);
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic wait_done(input int n_out, input int n_meta);
        int c = 0;
        while ((obs_out.size() < n_out || obs_meta.size() < n_meta) && c < 20000) begin
            @(negedge aclk);
            c++;
        end
        repeat (4) @(negedge aclk);
        #3;
    endtask

    task automatic test_reset();
        aresetn  = 1'b0;
        s_tdata  = rand_data();
        s_tkeep  = '1;
        s_tvalid = 1'b1;
        repeat (3) @(negedge aclk);
        #2;
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready got %b want 0", s_tready); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid got %b want 0", m_tvalid); end
        checks++; if (meta_valid !== 1'b0) begin errors++; $display("FAIL reset_meta_valid got %b want 0", meta_valid); end
        checks++; if ({meta_uncom, meta_com, meta_rcvd, meta_last, meta_err} !== 50'h0) begin
            errors++; $display("FAIL reset_meta_fields got %h want 0", {meta_uncom, meta_com, meta_rcvd, meta_last, meta_err}); end
        checks++; if (page_count !== 32'h0 || err_count !== 16'h0) begin
            errors++; $display("FAIL reset_counters got %h/%h want 0/0", page_count, err_count); end
        s_tvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        #2;
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL post_reset_s_tready got %b want 1", s_tready); end
    endtask

    task automatic test_single_page();
        do_reset();
        gaps = 1'b0; m_mode = 0; meta_mode = 0;
        in_q = '{mk_hdr(16'h1000, 16'h0080, 4'hF, 1'b0), mk_body(64, 1'b0), mk_body(64, 1'b1)};
        send_all();
        wait_done(2, 1);
        checks++; if (obs_out.size() != 2) begin errors++; $display("FAIL single_beats got %0d want 2", obs_out.size()); end
        if (obs_out.size() == 2) begin
            checks++; if (obs_out[0].last !== 1'b0 || obs_out[1].last !== 1'b1) begin
                errors++; $display("FAIL single_tlast got %b%b want 01", obs_out[0].last, obs_out[1].last); end
            checks++; if (obs_out[1].data !== in_q[2].data) begin
                errors++; $display("FAIL single_data got %h want %h", obs_out[1].data[63:0], in_q[2].data[63:0]); end
        end
        checks++; if (obs_meta.size() != 1 || obs_meta[0] !== meta_t'({16'h1000, 16'h0080, 16'h0080, 1'b1, 1'b0})) begin
            errors++; $display("FAIL single_meta got n=%0d %h want %h", obs_meta.size(),
                               obs_meta.size() > 0 ? obs_meta[0] : 50'h0, {16'h1000, 16'h0080, 16'h0080, 1'b1, 1'b0}); end
        checks++; if (page_count !== 32'd1) begin errors++; $display("FAIL single_page_count got %0d want 1", page_count); end
    endtask

    task automatic test_back_to_back();
        meta_t want[3];
        do_reset();
        gaps = 1'b0; m_mode = 0; meta_mode = 0;
        in_q = '{mk_hdr(16'hA000, 16'h0040, 4'hF, 1'b0), mk_body(64, 1'b0),
                 mk_hdr(16'hB000, 16'h007C, 4'hF, 1'b0), mk_body(64, 1'b0), mk_body(60, 1'b0),
                 mk_hdr(16'hC000, 16'h0040, 4'hF, 1'b0), mk_body(64, 1'b1)};
        want[0] = {16'hA000, 16'h0040, 16'h0040, 1'b0, 1'b0};
        want[1] = {16'hB000, 16'h007C, 16'h007C, 1'b0, 1'b0};
        want[2] = {16'hC000, 16'h0040, 16'h0040, 1'b1, 1'b0};
        send_all();
        wait_done(4, 3);
        checks++; if (stall_cycles != 0) begin errors++; $display("FAIL b2b_bubbles got %0d want 0", stall_cycles); end
        checks++; if (obs_out.size() != 4) begin errors++; $display("FAIL b2b_beats got %0d want 4", obs_out.size()); end
        if (obs_out.size() == 4) begin
            checks++; if ({obs_out[0].last, obs_out[1].last, obs_out[2].last, obs_out[3].last} !== 4'b1011) begin
                errors++; $display("FAIL b2b_tlast got %b%b%b%b want 1011", obs_out[0].last, obs_out[1].last,
                                   obs_out[2].last, obs_out[3].last); end
        end
        checks++; if (obs_meta.size() != 3) begin errors++; $display("FAIL b2b_meta_count got %0d want 3", obs_meta.size()); end
        for (int k = 0; k < 3 && k < obs_meta.size(); k++) begin
            checks++; if (obs_meta[k] !== want[k]) begin
                errors++; $display("FAIL b2b_meta[%0d] got %h want %h", k, obs_meta[k], want[k]); end
        end
    endtask

    task automatic test_overrun();
        beat_t b2;
        do_reset();
        gaps = 1'b0; m_mode = 0; meta_mode = 0;
        b2 = mk_body(64, 1'b0);
        b2.data[15:0] = 16'h0;   // leftover beat is parsed as a header with com=0
        in_q = '{mk_hdr(16'h2000, 16'h0040, 4'hF, 1'b0), mk_body(64, 1'b0), b2,
                 mk_hdr(16'h3000, 16'h0050, 4'hF, 1'b0), mk_body(64, 1'b0), mk_body(64, 1'b0)};
        send_all();
        wait_done(3, 3);
        checks++; if (obs_out.size() != 3) begin errors++; $display("FAIL ovr_beats got %0d want 3", obs_out.size()); end
        if (obs_out.size() == 3) begin
            checks++; if ({obs_out[0].last, obs_out[1].last, obs_out[2].last} !== 3'b101) begin
                errors++; $display("FAIL ovr_tlast got %b%b%b want 101", obs_out[0].last, obs_out[1].last, obs_out[2].last); end
        end
        checks++; if (obs_meta.size() != 3) begin errors++; $display("FAIL ovr_meta_count got %0d want 3", obs_meta.size()); end
        if (obs_meta.size() == 3) begin
            checks++; if (obs_meta[0] !== meta_t'({16'h2000, 16'h0040, 16'h0040, 1'b0, 1'b0})) begin
                errors++; $display("FAIL exact_meta got %h", obs_meta[0]); end
            checks++; if (obs_meta[1] !== meta_t'({b2.data[31:16], 16'h0000, 16'h0000, 1'b0, 1'b1})) begin
                errors++; $display("FAIL stray_hdr_meta got %h want %h", obs_meta[1], {b2.data[31:16], 34'h1}); end
            checks++; if (obs_meta[2] !== meta_t'({16'h3000, 16'h0050, 16'h0080, 1'b0, 1'b1})) begin
                errors++; $display("FAIL overrun_meta got %h", obs_meta[2]); end
        end
        checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL ovr_err_count got %0d want 2", err_count); end
    endtask

    task automatic test_underrun();
        do_reset();
        gaps = 1'b0; m_mode = 0; meta_mode = 0;
        in_q = '{mk_hdr(16'h4000, 16'h00C0, 4'hF, 1'b0), mk_body(64, 1'b1)};
        send_all();
        wait_done(1, 1);
        checks++; if (obs_out.size() != 1 || obs_out[0].last !== 1'b1) begin
            errors++; $display("FAIL udr_beat got n=%0d want 1 beat with tlast", obs_out.size()); end
        checks++; if (obs_meta.size() != 1 || obs_meta[0] !== meta_t'({16'h4000, 16'h00C0, 16'h0040, 1'b1, 1'b1})) begin
            errors++; $display("FAIL udr_meta got n=%0d %h", obs_meta.size(), obs_meta.size() > 0 ? obs_meta[0] : 50'h0); end
    endtask

    task automatic test_meta_stall();
        do_reset();
        gaps = 1'b0; m_mode = 0; meta_mode = 2;
        in_q = '{mk_hdr(16'h0010, 16'h0040, 4'hF, 1'b0), mk_body(64, 1'b0),
                 mk_hdr(16'h0020, 16'h0040, 4'hF, 1'b0), mk_body(64, 1'b0)};
        fork
            send_all();
            begin
                repeat (30) @(negedge aclk);
                #2;
                checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL stall_s_tready got %b want 0", s_tready); end
                checks++; if (meta_valid !== 1'b1 || {meta_uncom, meta_rcvd} !== {16'h0010, 16'h0040}) begin
                    errors++; $display("FAIL stall_held got v=%b u=%h r=%h want 1/0010/0040", meta_valid, meta_uncom, meta_rcvd); end
                checks++; if (obs_out.size() != 1) begin errors++; $display("FAIL stall_beats got %0d want 1", obs_out.size()); end
                meta_mode = 0;
            end
        join
        wait_done(2, 2);
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL stall_stability got %0d want 0", stab_viol); end
        checks++; if (obs_meta.size() != 2) begin errors++; $display("FAIL stall_meta_count got %0d want 2", obs_meta.size()); end
        if (obs_meta.size() == 2) begin
            checks++; if (obs_meta[1] !== meta_t'({16'h0020, 16'h0040, 16'h0040, 1'b0, 1'b0})) begin
                errors++; $display("FAIL stall_meta2 got %h", obs_meta[1]); end
        end
    endtask

    task automatic test_bad_header();
        do_reset();
        gaps = 1'b0; m_mode = 0; meta_mode = 0;
        in_q = '{mk_hdr(16'h1234, 16'h0040, 4'h3, 1'b0),
                 mk_hdr(16'h5000, 16'h0040, 4'hF, 1'b0), mk_body(64, 1'b1)};
        send_all();
        wait_done(1, 2);
        checks++; if (obs_out.size() != 1) begin errors++; $display("FAIL badhdr_beats got %0d want 1", obs_out.size()); end
        checks++; if (obs_meta.size() != 2) begin errors++; $display("FAIL badhdr_meta_count got %0d want 2", obs_meta.size()); end
        if (obs_meta.size() == 2) begin
            checks++; if (obs_meta[0] !== meta_t'({16'h1234, 16'h0040, 16'h0000, 1'b0, 1'b1})) begin
                errors++; $display("FAIL badhdr_meta got %h", obs_meta[0]); end
            checks++; if (obs_meta[1] !== meta_t'({16'h5000, 16'h0040, 16'h0040, 1'b1, 1'b0})) begin
                errors++; $display("FAIL badhdr_next_meta got %h", obs_meta[1]); end
        end
        checks++; if (err_count !== 16'd1 || page_count !== 32'd2) begin
            errors++; $display("FAIL badhdr_counters got %0d/%0d want 1/2", err_count, page_count); end
    endtask

    task automatic test_reset_midpage();
        do_reset();
        gaps = 1'b0; m_mode = 0; meta_mode = 0;
        in_q = '{mk_hdr(16'h6000, 16'h00C0, 4'hF, 1'b0), mk_body(64, 1'b0)};
        send_all();
        do_reset();
        in_q = '{mk_hdr(16'h7000, 16'h0040, 4'hF, 1'b0), mk_body(64, 1'b1)};
        send_all();
        wait_done(1, 1);
        checks++; if (obs_meta.size() != 1 || obs_meta[0] !== meta_t'({16'h7000, 16'h0040, 16'h0040, 1'b1, 1'b0})) begin
            errors++; $display("FAIL midreset_meta got n=%0d %h", obs_meta.size(), obs_meta.size() > 0 ? obs_meta[0] : 50'h0); end
        checks++; if (page_count !== 32'd1) begin errors++; $display("FAIL midreset_page_count got %0d want 1", page_count); end
    endtask

    task automatic test_random();
        int sum;
        int nb;
        int com;
        int kind;
        int n_err;
        bit stop;
        do_reset();
        gaps = 1'b1; m_mode = 1; meta_mode = 1;
        in_q.delete();
        for (int p = 0; p < 80; p++) begin
            kind = $urandom_range(0, 5);
            com  = $urandom_range(2, 260);
            sum  = 0;
            if (kind == 0) begin
                case ($urandom_range(0, 2))
                    0: in_q.push_back(mk_hdr(16'($urandom), 16'(com), 4'($urandom_range(0, 14)), 1'b0));
                    1: in_q.push_back(mk_hdr(16'($urandom), 16'h0, 4'hF, 1'b0));
                    default: in_q.push_back(mk_hdr(16'($urandom), 16'(com), 4'hF, 1'b1));
                endcase
            end else if (kind == 1) begin
                in_q.push_back(mk_hdr(16'($urandom), 16'(com), 4'hF, 1'b0));
                do begin
                    nb   = $urandom_range(1, (com - 1 - sum) < 64 ? (com - 1 - sum) : 64);
                    sum += nb;
                    stop = (sum >= com - 1) || ($urandom_range(0, 1) == 1);
                    in_q.push_back(mk_body(nb, stop));
                end while (!stop);
            end else begin
                in_q.push_back(mk_hdr(16'($urandom), 16'(com), 4'hF, 1'b0));
                do begin
                    nb   = $urandom_range(1, 64);
                    sum += nb;
                    stop = (sum >= com);
                    in_q.push_back(mk_body(nb, stop && ($urandom_range(0, 3) == 0)));
                end while (!stop);
            end
        end
        run_model();
        send_all();
        wait_done(exp_out.size(), exp_meta.size());
        checks++; if (obs_out.size() != exp_out.size()) begin
            errors++; $display("FAIL rand_beat_count got %0d want %0d", obs_out.size(), exp_out.size()); end
        for (int k = 0; k < exp_out.size() && k < obs_out.size(); k++) begin
            checks++;
            if (obs_out[k].data !== exp_out[k].data || obs_out[k].keep !== exp_out[k].keep || obs_out[k].last !== exp_out[k].last) begin
                errors++;
                $display("FAIL rand_beat[%0d] got d=%h k=%h l=%b want d=%h k=%h l=%b", k, obs_out[k].data[63:0],
                         obs_out[k].keep, obs_out[k].last, exp_out[k].data[63:0], exp_out[k].keep, exp_out[k].last);
            end
        end
        checks++; if (obs_meta.size() != exp_meta.size()) begin
            errors++; $display("FAIL rand_meta_count got %0d want %0d", obs_meta.size(), exp_meta.size()); end
        n_err = 0;
        foreach (exp_meta[k]) if (exp_meta[k].err) n_err++;
        for (int k = 0; k < exp_meta.size() && k < obs_meta.size(); k++) begin
            checks++; if (obs_meta[k] !== exp_meta[k]) begin
                errors++; $display("FAIL rand_meta[%0d] got %h want %h", k, obs_meta[k], exp_meta[k]); end
        end
        checks++; if (page_count !== 32'(exp_meta.size()) || err_count !== 16'(n_err)) begin
            errors++; $display("FAIL rand_counters got %0d/%0d want %0d/%0d", page_count, err_count, exp_meta.size(), n_err); end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL rand_meta_stability got %0d want 0", stab_viol); end
    endtask

    initial begin
        test_reset();
        test_single_page();
        test_back_to_back();
        test_overrun();
        test_underrun();
        test_meta_stall();
        test_bad_header();
        test_reset_midpage();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
